// File: rtl/bcd_score_if.sv
// Bus between the game FSM and a bcd_score_display instance: control pulses in,
// packed-BCD score, best score, seven-segment drive and status flags out.
interface bcd_score_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    inc;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] best;
  logic [7*NUM_DIGITS-1:0] display;
  logic                    carry;
  logic                    ovf;

  modport master (
    output clear, load, load_val, inc,
    input  count, best, display, carry, ovf
  );

  modport slave (
    input  clear, load, load_val, inc,
    output count, best, display, carry, ovf
  );
endinterface

// File: rtl/bcd_score_display.sv
// Multi-digit packed-BCD score counter with best-score register and active-low
// seven-segment decode. Define BCD_SCORE_BLANK_EN for leading-zero blanking.
module bcd_score_display #(
  parameter int NUM_DIGITS = 3,
  parameter bit SATURATE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  bcd_score_if.slave  bus
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]            count_q, count_d;
  logic [W-1:0]            best_q, best_d;
  logic                    ovf_q, ovf_d;
  logic                    all9;
  logic [7*NUM_DIGITS-1:0] disp;
  logic                    hi_nz;

  // Ripple +1 across every digit in a single cycle.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all9 = 1'b0;
    end
  end

  assign bus.carry = bus.inc & ~bus.clear & ~bus.load & all9;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = bcd_sanitize(bus.load_val);
    end else if (bus.inc) begin
      if (all9) begin
        count_d = SATURATE ? count_q : '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = bcd_inc(count_q);
      end
    end
  end

  // Valid BCD orders the same as plain binary, so a direct compare is exact.
  assign best_d = (count_q > best_q) ? count_q : best_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      best_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      best_q  <= best_d;
      ovf_q   <= ovf_d;
    end
  end

  // Walk from the top digit down so hi_nz tells whether any digit at or above i is nonzero.
  always_comb begin
    disp  = '1;
    hi_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_nz = hi_nz | (count_q[4*i +: 4] != 4'd0);
`ifdef BCD_SCORE_BLANK_EN
      if (i == 0 || hi_nz) disp[7*i +: 7] = seg7(count_q[4*i +: 4]);
      else                 disp[7*i +: 7] = 7'b1111111;
`else
      disp[7*i +: 7] = seg7(count_q[4*i +: 4]);
`endif
    end
  end

  assign bus.count   = count_q;
  assign bus.best    = best_q;
  assign bus.ovf     = ovf_q;
  assign bus.display = disp;
endmodule
